// File: rtl/prism_loader_pkg.sv
// -----------------------------------------------------------------------------
// prism_loader_pkg
// Shared types and constants for the PRISM serial loader.
//   state_t        : loader FSM states
//   CMD_BITS       : bits in the command byte
//   WR_FRAME_BITS  : total bits in a write frame (command + data)
//   RD_BITS        : response bits shifted back to the host on a read
//   BUS_IDLE/BUS_32: TinyQV strobe codes (idle / 32-bit access)
//   RD_FILL        : word returned to the host when a read times out
// -----------------------------------------------------------------------------
package prism_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        WRITE,
        READ,
        RDATA,
        DONE
    } state_t;

    localparam int          CMD_BITS      = 8;
    localparam int          WR_FRAME_BITS = 40;
    localparam int          RD_BITS       = 32;
    localparam logic [1:0]  BUS_IDLE      = 2'b11;
    localparam logic [1:0]  BUS_32        = 2'b10;
    localparam logic [31:0] RD_FILL       = 32'hDEAD_BEEF;

    // States in which the host is still moving bits; leaving one of them
    // straight back to IDLE means the frame was cut short.
    function automatic logic is_frame_state(input state_t s);
        return (s == CMD) || (s == WDATA) || (s == RDATA);
    endfunction

endpackage

// File: rtl/prism_loader_edge.sv
// -----------------------------------------------------------------------------
// prism_loader_edge
// Edge detector for the host pins. sclk and cs_n arrive already synchronized
// to clk; this block keeps one previous sample of each and produces
// single-clk pulses.
//   clk, rst_n : system clock, async active-low reset
//   sclk, cs_n : synchronized host serial clock / frame select
//   sclk_rise  : sclk high now, low on the previous clk
//   sclk_fall  : sclk low now, high on the previous clk
//   cs_fall    : frame start (cs_n high -> low)
//   cs_rise    : frame end   (cs_n low  -> high)
// -----------------------------------------------------------------------------
module prism_loader_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic sclk_q;
    logic cs_n_q;

    // Reset to the idle levels of the pins so that releasing reset with the
    // host idle produces no spurious edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            cs_n_q <= 1'b1;
        end else begin
            // NOTE: registers are written with <= so every flop samples the
            // pre-edge value of its inputs, independent of statement order.
            sclk_q <= sclk;
            cs_n_q <= cs_n;
        end
    end

    assign sclk_rise = sclk  & ~sclk_q;
    assign sclk_fall = ~sclk & sclk_q;
    assign cs_fall   = ~cs_n & cs_n_q;
    assign cs_rise   = cs_n  & ~cs_n_q;

endmodule

// File: rtl/tqvp_prism_loader.sv
// -----------------------------------------------------------------------------
// tqvp_prism_loader
// SPI-mode-0 slave that turns host frames into 32-bit TinyQV peripheral
// register writes and reads, returning read data serially.
//   clk, rst_n   : system clock, async active-low reset
//   sclk, cs_n,
//   mosi         : synchronized host serial clock / select / data in
//   miso         : serial read data back to the host
//   address      : register address, latched from the command byte
//   data_in      : write data, shifted in from the host
//   data_write_n : 11 idle, 10 one-clk 32-bit write
//   data_read_n  : 11 idle, 10 while a 32-bit read is pending
//   data_out     : read data from the peripheral
//   data_ready   : read data valid
//   busy         : loader is not in IDLE
//   frame_err    : one-clk pulse on an aborted frame or a read timeout
// Frame: command byte {rw, reserved, addr[5:0]} MSB first; writes carry 32
// more data bits, reads return 32 bits on miso.
// -----------------------------------------------------------------------------
module tqvp_prism_loader #(
    parameter int RD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    output logic [5:0]  address,
    output logic [31:0] data_in,
    output logic [1:0]  data_write_n,
    output logic [1:0]  data_read_n,
    input  logic [31:0] data_out,
    input  logic        data_ready,
    output logic        busy,
    output logic        frame_err
);

    import prism_loader_pkg::*;

    localparam logic [5:0] CMD_LAST = 6'(CMD_BITS - 1);
    localparam logic [5:0] WR_LAST  = 6'(WR_FRAME_BITS - 1);
    localparam logic [5:0] RD_LAST  = 6'(RD_BITS - 1);
    localparam logic [7:0] TMO_LAST = 8'(RD_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;

    logic        sclk_rise;
    logic        sclk_fall;
    logic        cs_fall;
    logic        cs_rise;

    logic [5:0]  bit_cnt;     // frame bits in CMD/WDATA, tx shifts in RDATA
    logic [6:0]  cmd_sr;      // first seven command bits, MSB first
    logic [31:0] tx_sr;       // read word on its way out to the host
    logic [7:0]  tmo_cnt;     // clks spent in READ, saturating
    logic        rise_seen;   // a response-phase sclk rise has happened

    logic        cmd_last;
    logic        wr_last;
    logic        tx_shift;
    logic        rd_last;
    logic        tmo_expired;

    logic [1:0]  write_n_d;
    logic [1:0]  read_n_d;
    logic        frame_err_d;

    prism_loader_edge u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    // ------------------------------------------------------------------
    // Frame progress decode
    // ------------------------------------------------------------------
    assign cmd_last    = (state == CMD)   && sclk_rise && (bit_cnt == CMD_LAST);
    assign wr_last     = (state == WDATA) && sclk_rise && (bit_cnt == WR_LAST);
    // The falling edge that closes the command byte arrives before any
    // response rise; it must not consume tx[31], so only falls that follow
    // a response-phase rise shift the word.
    assign tx_shift    = (state == RDATA) && sclk_fall && rise_seen;
    assign rd_last     = tx_shift && (bit_cnt == RD_LAST);
    assign tmo_expired = (state == READ) && !data_ready && (tmo_cnt == TMO_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no
        // latch is inferred for next_state.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (cs_fall) next_state = CMD;
            end
            CMD: begin
                if (cs_rise)       next_state = IDLE;
                else if (cmd_last) next_state = cmd_sr[6] ? WDATA : READ;
            end
            WDATA: begin
                if (cs_rise)      next_state = IDLE;
                else if (wr_last) next_state = WRITE;
            end
            WRITE: begin
                // The strobe always completes; a host that already let go
                // of cs_n skips DONE.
                next_state = cs_n ? IDLE : DONE;
            end
            READ: begin
                if (data_ready || tmo_expired) next_state = cs_n ? IDLE : RDATA;
            end
            RDATA: begin
                // The final shift wins over a simultaneous cs_n rise so a
                // fully delivered word is never reported as aborted.
                if (rd_last)      next_state = DONE;
                else if (cs_rise) next_state = IDLE;
            end
            DONE: begin
                if (cs_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        write_n_d   = (state == WRITE) ? BUS_32 : BUS_IDLE;
        read_n_d    = (next_state == READ) ? BUS_32 : BUS_IDLE;
        frame_err_d = tmo_expired ||
                      (is_frame_state(state) && (next_state == IDLE));
    end

    // Strobes and the error pulse are registered so the bus sees clean,
    // glitch-free levels; reset still forces them idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_write_n <= BUS_IDLE;
            data_read_n  <= BUS_IDLE;
            frame_err    <= 1'b0;
        end else begin
            data_write_n <= write_n_d;
            data_read_n  <= read_n_d;
            frame_err    <= frame_err_d;
        end
    end

    assign busy = (state != IDLE);
    assign miso = (state == RDATA) & tx_sr[31];

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            address   <= '0;
            data_in   <= '0;
            tx_sr     <= '0;
            tmo_cnt   <= '0;
            rise_seen <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bit_cnt <= '0;
                end
                CMD: begin
                    rise_seen <= 1'b0;
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        cmd_sr  <= {cmd_sr[5:0], mosi};
                    end
                    if (cmd_last) begin
                        address <= {cmd_sr[4:0], mosi};
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        data_in <= {data_in[30:0], mosi};
                    end
                end
                READ: begin
                    bit_cnt <= '0;
                    if (sclk_rise) rise_seen <= 1'b1;
                    if (data_ready) begin
                        tx_sr <= data_out;
                    end else if (tmo_expired) begin
                        tx_sr <= RD_FILL;
                    end
                end
                RDATA: begin
                    if (sclk_rise) rise_seen <= 1'b1;
                    if (tx_shift) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        tx_sr   <= {tx_sr[30:0], 1'b0};
                    end
                end
                default: ;
            endcase

            // Counts clks inside READ only; restarts on every entry.
            if (state != READ) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tqvp_prism_loader.sv
// -----------------------------------------------------------------------------
// tb_tqvp_prism_loader
// Directed bench: a host model clocks frames at sclk = clk/4 while a monitor
// logs every bus strobe and error pulse; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_tqvp_prism_loader;

    logic        clk;
    logic        rst_n;
    logic        sclk;
    logic        cs_n;
    logic        mosi;
    logic        miso;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        busy;
    logic        frame_err;

    tqvp_prism_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .miso         (miso),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors    = 0;
    int miscompares = 0;

    // Bus / error monitor, sampled on the falling clk edge.
    logic [5:0]  wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_cyc  [16];
    int          wr_cnt       = 0;
    int          bad_codes    = 0;
    int          rd_cycles    = 0;
    int          rd_start_cyc = 0;
    logic [5:0]  rd_addr      = '0;
    logic        rd_prev      = 1'b0;
    int          err_cnt      = 0;

    always @(negedge clk) begin
        if (data_write_n == 2'b10) begin
            if (wr_cnt < 16) begin
                wr_addr[wr_cnt] = address;
                wr_data[wr_cnt] = data_in;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt++;
        end else if (data_write_n != 2'b11) begin
            bad_codes++;
        end
        if (data_read_n == 2'b10) begin
            rd_cycles++;
            if (!rd_prev) begin
                rd_start_cyc = cyc;
                rd_addr      = address;
            end
        end
        rd_prev = (data_read_n == 2'b10);
        if (frame_err) err_cnt++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed no completion, required finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- host model ----------------
    int last_rise_cyc = 0;

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        clocks(2);
        sclk = 1'b1;
        last_rise_cyc = cyc;
        clocks(2);
        sclk = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        clocks(2);
        sclk = 1'b1;
        b = miso;
        clocks(2);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic recv_word(output logic [31:0] v);
        logic b;
        v = '0;
        for (int i = 31; i >= 0; i--) begin
            recv_bit(b);
            v[i] = b;
        end
    endtask

    task automatic start_frame();
        cs_n = 1'b0;
        clocks(2);
    endtask

    task automatic end_frame(input int gap);
        cs_n = 1'b1;
        clocks(gap);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, " write_n"},   {30'd0, data_write_n}, 32'h3);
        check({pfx, " read_n"},    {30'd0, data_read_n},  32'h3);
        check({pfx, " miso"},      {31'd0, miso},         32'h0);
        check({pfx, " busy"},      {31'd0, busy},         32'h0);
        check({pfx, " frame_err"}, {31'd0, frame_err},    32'h0);
        check({pfx, " address"},   {26'd0, address},      32'h0);
        check({pfx, " data_in"},   data_in,               32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] word;
        logic        bit_v;
        int          w0, e0, r0, rise8;

        rst_n      = 1'b0;
        sclk       = 1'b0;
        cs_n       = 1'b1;
        mosi       = 1'b0;
        data_out   = '0;
        data_ready = 1'b0;
        clocks(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        clocks(3);

        // 1. write 0x80 / 0x2000_0003
        start_frame();
        send_byte(8'h80);
        send_word(32'h2000_0003);
        check("wr busy in DONE", {31'd0, busy}, 32'h1);
        end_frame(3);
        check("wr count",   wr_cnt, 1);
        check("wr address", {26'd0, wr_addr[0]}, 32'h00);
        check("wr data",    wr_data[0], 32'h2000_0003);
        check("wr latency", wr_cyc[0], last_rise_cyc + 2);
        check("wr busy after cs_n", {31'd0, busy}, 32'h0);
        check("wr data_in held", data_in, 32'h2000_0003);

        // 2. read 0x18 with data ready immediately
        data_out   = 32'h0000_02A5;
        data_ready = 1'b1;
        r0 = rd_cycles;
        start_frame();
        send_byte(8'h18);
        rise8 = last_rise_cyc;
        recv_word(word);
        end_frame(3);
        check("rd strobe cycles", rd_cycles - r0, 1);
        check("rd latency",       rd_start_cyc, rise8 + 1);
        check("rd address",       {26'd0, rd_addr}, 32'h18);
        check("rd host word",     word, 32'h0000_02A5);
        check("rd no error",      err_cnt, 0);
        check("rd busy after",    {31'd0, busy}, 32'h0);

        // 3. read 0x05 with data_ready low: timeout after 255 clk
        data_ready = 1'b0;
        data_out   = 32'h1234_5678;
        r0 = rd_cycles;
        e0 = err_cnt;
        start_frame();
        send_byte(8'h05);
        clocks(300);
        recv_word(word);
        check("tmo strobe cycles", rd_cycles - r0, 255);
        check("tmo frame_err",     err_cnt - e0, 1);
        check("tmo host word",     word, 32'hDEAD_BEEF);
        recv_bit(bit_v);
        check("DONE extra sclk miso", {31'd0, bit_v}, 32'h0);
        check("DONE extra sclk busy", {31'd0, busy}, 32'h1);
        end_frame(3);
        check("tmo busy after", {31'd0, busy}, 32'h0);

        // 4. write aborted after 20 bits, then a normal write
        w0 = wr_cnt;
        e0 = err_cnt;
        start_frame();
        send_byte(8'h80);
        for (int i = 31; i >= 20; i--) send_bit(1'b1);
        end_frame(3);
        check("abort frame_err", err_cnt - e0, 1);
        check("abort no write",  wr_cnt - w0, 0);
        check("abort busy",      {31'd0, busy}, 32'h0);
        start_frame();
        send_byte(8'hC7);
        send_word(32'hA5A5_0F0F);
        end_frame(3);
        check("post-abort count",   wr_cnt - w0, 1);
        check("post-abort address", {26'd0, wr_addr[w0]}, 32'h07);
        check("post-abort data",    wr_data[w0], 32'hA5A5_0F0F);

        // 5. reset mid-WDATA, then write 0x80 / 0x1
        w0 = wr_cnt;
        e0 = err_cnt;
        start_frame();
        send_byte(8'h80);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        cs_n = 1'b1;
        clocks(3);
        rst_n = 1'b1;
        clocks(3);
        check("reset silent", err_cnt - e0, 0);
        start_frame();
        send_byte(8'h80);
        send_word(32'h0000_0001);
        end_frame(3);
        check("post-reset count",   wr_cnt - w0, 1);
        check("post-reset address", {26'd0, wr_addr[w0]}, 32'h00);
        check("post-reset data",    wr_data[w0], 32'h0000_0001);

        // 6. back-to-back writes with a 1-clk cs_n-high gap
        w0 = wr_cnt;
        start_frame();
        send_byte(8'h8A);
        send_word(32'h1111_2222);
        end_frame(1);
        start_frame();
        send_byte(8'h95);
        send_word(32'h3333_4444);
        end_frame(3);
        check("b2b count",     wr_cnt - w0, 2);
        check("b2b addr 0",    {26'd0, wr_addr[w0]},     32'h0A);
        check("b2b data 0",    wr_data[w0],              32'h1111_2222);
        check("b2b addr 1",    {26'd0, wr_addr[w0 + 1]}, 32'h15);
        check("b2b data 1",    wr_data[w0 + 1],          32'h3333_4444);
        check("strobe codes",  bad_codes, 0);
        check("busy idle end", {31'd0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
